// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited imem requests and a
// fall-through FIFO of {pc, instr} drained by decode; redirects flush and squash wrong-path data.
module fetch_queue #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PC_STEP     = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect_valid,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [ADDR_WIDTH-1:0]      imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]     imem_rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [CntW-1:0]        outst_q, outst_d;
  logic [CntW-1:0]        drop_q, drop_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [PtrW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [PtrW-1:0]        tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [ADDR_WIDTH-1:0]  tag_q        [DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] fifo_instr_q [DEPTH];

  logic            req_fire, pop, push;
  logic [CntW:0]   credit_sum;

  // Buffered plus in-flight entries never exceed DEPTH, so the FIFO cannot overflow.
  assign credit_sum     = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = rst_n & (credit_sum < DepthC);
  assign imem_req_addr  = pc_q;

  assign out_valid = (count_q != '0);
  assign out_instr = fifo_instr_q[rd_q];
  assign out_pc    = fifo_pc_q[rd_q];
  assign occupancy = count_q;

  always_comb begin
    req_fire = imem_req_valid & imem_req_ready;
    pop      = out_valid & out_ready;
    push     = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;

    outst_d = outst_q;
    if (req_fire && !imem_rsp_valid)      outst_d = outst_q + CntW'(1);
    else if (!req_fire && imem_rsp_valid) outst_d = outst_q - CntW'(1);

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);

    wr_d     = push ? wr_q + PtrW'(1) : wr_q;
    rd_d     = pop ? rd_q + PtrW'(1) : rd_q;
    tag_wr_d = req_fire ? tag_wr_q + PtrW'(1) : tag_wr_q;
    tag_rd_d = imem_rsp_valid ? tag_rd_q + PtrW'(1) : tag_rd_q;
    pc_d     = req_fire ? pc_q + ADDR_WIDTH'(PC_STEP) : pc_q;

    drop_d = drop_q;
    if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CntW'(1);

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      // Everything still in flight after this cycle is wrong-path.
      drop_d  = outst_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      count_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i]        <= '0;
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      if (req_fire) tag_q[tag_wr_q] <= pc_q;
      if (push) begin
        fifo_pc_q[wr_q]    <= tag_q[tag_rd_q];
        fifo_instr_q[wr_q] <= imem_rsp_data;
      end
    end
  end

  // Memory protocol: a response must always match an earlier accepted request.
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
                                  imem_rsp_valid |-> outst_q != '0);

endmodule
